// File: rtl/branch_pkg.sv
// Shared branch definitions: condition codes, counter reset value and the
// condition resolver used by branch_predict_checker.
package branch_pkg;

  localparam logic [2:0] COND_NONE = 3'd0;
  localparam logic [2:0] COND_JUMP = 3'd1;
  localparam logic [2:0] COND_BEZ  = 3'd2;
  localparam logic [2:0] COND_BNE  = 3'd3;
  localparam logic [2:0] COND_BEQ  = 3'd4;
  localparam logic [2:0] COND_BLTZ = 3'd5;
  localparam logic [2:0] COND_BGEZ = 3'd6;
  localparam logic [2:0] COND_BGTZ = 3'd7;

  localparam logic [1:0] CNT_RESET = 2'b01;

  // Operands are sign-extended to this width before resolving, so the one
  // function serves every WORD_LEN up to 64.
  localparam int unsigned OPND_W = 64;

  function automatic logic cond_taken(input logic [2:0]        cond,
                                      input logic signed [OPND_W-1:0] reg1,
                                      input logic signed [OPND_W-1:0] reg2);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_NONE: taken = 1'b0;
      COND_JUMP: taken = 1'b1;
      COND_BEZ:  taken = (reg1 == '0);
      COND_BNE:  taken = (reg1 != reg2);
      COND_BEQ:  taken = (reg1 == reg2);
      COND_BLTZ: taken = (reg1 < 0);
      COND_BGEZ: taken = (reg1 >= 0);
      COND_BGTZ: taken = (reg1 > 0);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit saturating counters with an asynchronous
// read port and a single saturating update port.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt [DEPTH];
  logic [1:0] cur;
  logic [1:0] nxt;

  assign cur      = cnt[wr_idx];
  assign rd_taken = cnt[rd_idx][1];

  always_comb begin
    nxt = cur;
    if (wr_taken) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
  end

  // Read is combinational off the registered array, so a same-cycle update
  // is only seen on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= CNT_RESET;
    end else if (wr_en) begin
      cnt[wr_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_predict_checker.sv
// Branch condition resolver with 2-bit counter prediction table.
// Optional statistics outputs when BRANCH_STATS_EN is defined.
module branch_predict_checker
  import branch_pkg::*;
#(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned PC_LEN    = 32,
  parameter int unsigned BHT_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_LEN-1:0]   lookup_pc,
  output logic                pred_taken,
  input  logic                resolve_valid,
  input  logic [PC_LEN-1:0]   resolve_pc,
  input  logic [2:0]          cond,
  input  logic [WORD_LEN-1:0] reg1,
  input  logic [WORD_LEN-1:0] reg2,
  input  logic                pred_in,
  input  logic                flush_in,
  output logic                br_cond,
  output logic                mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]         branch_count,
  output logic [15:0]         mispredict_count
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic signed [OPND_W-1:0] reg1_x;
  logic signed [OPND_W-1:0] reg2_x;
  logic                     taken;
  logic                     live;
  logic                     wrong;
  logic                     upd;
  logic [IDX_W-1:0]         lookup_idx;
  logic [IDX_W-1:0]         resolve_idx;

  assign reg1_x = OPND_W'(signed'(reg1));
  assign reg2_x = OPND_W'(signed'(reg2));
  assign taken  = cond_taken(cond, reg1_x, reg2_x);

  assign live  = resolve_valid && !flush_in;
  assign wrong = (taken != pred_in);
  // Unconditional jumps and no-branch never train the table.
  assign upd   = live && (cond >= COND_BEZ);

  assign lookup_idx  = lookup_pc[IDX_W+1:2];
  assign resolve_idx = resolve_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_LEN-1:IDX_W+2], lookup_pc[1:0],
                            resolve_pc[PC_LEN-1:IDX_W+2], resolve_pc[1:0]};

  branch_history_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_idx),
    .rd_taken (pred_taken),
    .wr_en    (upd),
    .wr_idx   (resolve_idx),
    .wr_taken (taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cond    <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      br_cond    <= live && taken;
      mispredict <= live && wrong;
    end
  end

`ifdef BRANCH_STATS_EN
  logic counted;
  assign counted = live && (cond != COND_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (counted) begin
      if (branch_count != '1) branch_count <= branch_count + 16'd1;
      if (wrong && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 16'd1;
    end
  end
`endif

endmodule
